// File: rtl/pixel_stream_pkg.sv
// Shared types and helpers for the pixel stream frame sequencer.
package pixel_stream_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_GAP    = 2'd3
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] pixel;
        logic             sof;
        logic             eol;
        logic             eof;
    } pix_entry_t;

    // Room for one more request once every in-flight pixel has landed in the FIFO.
    function automatic logic credit_ok(input logic [31:0] occ, input logic req,
                                       input logic cap, input logic [31:0] depth);
        return (occ + {31'd0, req} + {31'd0, cap} + 32'd1) <= depth;
    endfunction

endpackage

// File: rtl/pixel_stream_fifo.sv
// Show-ahead capture FIFO: the head entry is presented while not_empty is high.
module pixel_stream_fifo
    import pixel_stream_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  pix_entry_t             push_data,
    input  logic                   pop,
    output pix_entry_t             head,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int AW = $clog2(DEPTH);

    pix_entry_t    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_pop_s;
    logic          full_s;

    assign do_pop_s  = pop && (count_r != '0);
    assign full_s    = (count_r == (AW+1)'(DEPTH));
    assign head      = mem_r[rd_ptr_r];
    assign not_empty = (count_r != '0);
    assign occupancy = count_r;

    // Storage, pointers and occupancy; storage is cleared so the outputs read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    pixel_stream_fifo_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .full  (full_s)
    );

endmodule

// File: rtl/pixel_stream_fifo_chk.sv
// Property checks for the capture FIFO.
module pixel_stream_fifo_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic full
);

    // The credit rule upstream must never let a push reach a full FIFO.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

// File: rtl/pixel_stream_ctrl.sv
// Frame sequencer: meters producer credit, captures one image per frame into a FIFO
// and forwards it downstream with SOF/EOL/EOF markers, with an idle gap between frames.
module pixel_stream_ctrl
    import pixel_stream_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 32,
    parameter int IMAGE_HEIGHT = 32,
    parameter int GAP_CYCLES   = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic             sensor_clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       frame_count,
    output logic             prod_ready,
    input  logic             prod_valid,
    input  logic [PIX_W-1:0] prod_pixel,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eol,
    output logic             out_eof,
    output logic             busy,
    output logic [7:0]       frames_done,
    output logic             proto_err
);

    localparam int IMG_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int IW = $clog2(IMG_SIZE + 1);
    localparam int XW = $clog2(IMAGE_WIDTH);
    localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int OW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_r, next_state_s;
    logic          prod_ready_r, cap_r, busy_r, proto_err_r, stop_pending_r;
    logic [IW-1:0] issued_r;
    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic [GW-1:0] gap_cnt_r;
    logic [7:0]    fc_r, frames_done_r;
    logic          issue_s, drain_done_s, last_frame_s;
    logic [OW-1:0] occ_s;
    pix_entry_t    push_entry_s, head_s;

    assign last_frame_s = (fc_r != 8'd0) && ((frames_done_r + 8'd1) == fc_r);

    assign push_entry_s.pixel = prod_pixel;
    assign push_entry_s.sof   = (x_r == '0) && (y_r == '0);
    assign push_entry_s.eol   = (x_r == XW'(IMAGE_WIDTH - 1));
    assign push_entry_s.eof   = push_entry_s.eol && (y_r == YW'(IMAGE_HEIGHT - 1));

    // Next-state and per-cycle strobes.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        drain_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_STREAM;
                else       next_state_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (issued_r == IW'(IMG_SIZE)) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    issue_s      = credit_ok(32'(occ_s), prod_ready_r, cap_r, 32'(FIFO_DEPTH));
                    next_state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (!prod_ready_r && !cap_r && (occ_s == '0)) begin
                    drain_done_s = 1'b1;
                    if (stop_pending_r || stop || last_frame_s) next_state_s = ST_IDLE;
                    else                                        next_state_s = ST_GAP;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (stop)                                      next_state_s = ST_IDLE;
                else if (gap_cnt_r == GW'(GAP_CYCLES - 1))     next_state_s = ST_STREAM;
                else                                           next_state_s = ST_GAP;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    // Credit pipeline, position/frame counters and status flags.
    always_ff @(posedge sensor_clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_ready_r   <= 1'b0;
            cap_r          <= 1'b0;
            busy_r         <= 1'b0;
            proto_err_r    <= 1'b0;
            stop_pending_r <= 1'b0;
            issued_r       <= '0;
            x_r            <= '0;
            y_r            <= '0;
            gap_cnt_r      <= '0;
            fc_r           <= 8'd0;
            frames_done_r  <= 8'd0;
        end else begin
            prod_ready_r <= issue_s;
            cap_r        <= prod_ready_r;
            busy_r       <= (next_state_s != ST_IDLE);
            if (cap_r && !prod_valid) proto_err_r <= 1'b1;

            if ((state_r == ST_IDLE) && start) begin
                fc_r          <= frame_count;
                frames_done_r <= 8'd0;
            end else if (drain_done_s) begin
                frames_done_r <= frames_done_r + 8'd1;
            end

            if (drain_done_s)  issued_r <= '0;
            else if (issue_s)  issued_r <= issued_r + 1'b1;

            if (drain_done_s) begin
                x_r <= '0;
                y_r <= '0;
            end else if (cap_r) begin
                if (x_r == XW'(IMAGE_WIDTH - 1)) begin
                    x_r <= '0;
                    y_r <= (y_r == YW'(IMAGE_HEIGHT - 1)) ? '0 : y_r + 1'b1;
                end else begin
                    x_r <= x_r + 1'b1;
                end
            end

            gap_cnt_r <= ((state_r == ST_GAP) && (next_state_s == ST_GAP)) ? gap_cnt_r + 1'b1 : '0;

            // A stop is remembered until the sequencer actually returns to IDLE.
            if (next_state_s == ST_IDLE)              stop_pending_r <= 1'b0;
            else if (stop && (state_r != ST_IDLE))    stop_pending_r <= 1'b1;
        end
    end

    pixel_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (sensor_clk),
        .rst_n     (rst_n),
        .push      (cap_r),
        .push_data (push_entry_s),
        .pop       (out_ready),
        .head      (head_s),
        .not_empty (out_valid),
        .occupancy (occ_s)
    );

    assign prod_ready  = prod_ready_r;
    assign out_pixel   = head_s.pixel;
    assign out_sof     = head_s.sof;
    assign out_eol     = head_s.eol;
    assign out_eof     = head_s.eof;
    assign busy        = busy_r;
    assign frames_done = frames_done_r;
    assign proto_err   = proto_err_r;

endmodule

// File: tb/tb_pixel_stream_ctrl.sv
// Directed self-checking bench for pixel_stream_ctrl with a small image producer model.
module tb_pixel_stream_ctrl;

    localparam int W = 4, H = 2, GAP = 5, DEPTH = 4, N = W * H;

    logic       sensor_clk = 1'b0;
    logic       rst_n, start, stop, prod_ready, prod_valid, out_valid, out_ready;
    logic [7:0] frame_count, prod_pixel, out_pixel, frames_done;
    logic       out_sof, out_eol, out_eof, busy, proto_err;

    typedef struct packed {
        logic [7:0] pix;
        logic       sof;
        logic       eol;
        logic       eof;
    } rx_t;

    rx_t got_q[$];
    int  gap_q[$];
    int  zero_run = 0;
    int  max_occ  = 0;
    int  n_checks = 0;
    int  n_fail   = 0;
    int  drop_req = 0;
    int  drop_done;
    bit  rnd_mode = 1'b0;

    pixel_stream_ctrl #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .sensor_clk (sensor_clk), .rst_n (rst_n), .start (start), .stop (stop),
        .frame_count(frame_count), .prod_ready(prod_ready), .prod_valid(prod_valid),
        .prod_pixel (prod_pixel), .out_pixel(out_pixel), .out_valid(out_valid),
        .out_ready  (out_ready), .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
        .busy       (busy), .frames_done(frames_done), .proto_err(proto_err)
    );

    always #5 sensor_clk = ~sensor_clk;

    // Image pixel i is 0x11*(i+1): 11,22,...,88.
    function automatic logic [7:0] img(input int i);
        logic [7:0] v;
        v = 8'(i + 1);
        return {v[3:0], v[3:0]};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Producer: presents image[idx] one edge after it sees ready.
    initial begin
        int  idx;
        logic rdy_seen;
        idx = 0; drop_done = 0; prod_valid = 1'b0; prod_pixel = 8'd0;
        forever begin
            @(negedge sensor_clk);
            rdy_seen = prod_ready;
            @(posedge sensor_clk);
            #1;
            if (!rst_n) begin
                idx = 0; prod_valid = 1'b0;
            end else if (rdy_seen) begin
                prod_pixel = img(idx);
                idx        = (idx + 1) % N;
                if (drop_req != drop_done) begin
                    prod_valid = 1'b0;
                    drop_done++;
                end else begin
                    prod_valid = 1'b1;
                end
            end else begin
                prod_valid = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge sensor_clk);
            #1;
            out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: record accepted pixels, idle runs of prod_ready and peak occupancy.
    always @(negedge sensor_clk) begin
        if (out_valid && out_ready) got_q.push_back({out_pixel, out_sof, out_eol, out_eof});
        if (!prod_ready) zero_run++;
        else if (zero_run > 0) begin
            gap_q.push_back(zero_run);
            zero_run = 0;
        end
        if (int'(dut.occ_s) > max_occ) max_occ = int'(dut.occ_s);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge sensor_clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge sensor_clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) begin
            @(posedge sensor_clk); #1;
        end
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic wait_pixels(input string tag, input int base, input int cnt);
        for (int i = 0; i < 1000 && (got_q.size() - base) < cnt; i++) begin
            @(posedge sensor_clk); #1;
        end
        check_eq({tag, "_reached"}, 32'((got_q.size() - base) >= cnt), 32'd1);
    endtask

    task automatic check_pixels(input string tag, input int base, input int nf);
        logic [10:0] e;
        check_eq({tag, "_count"}, 32'(got_q.size() - base), 32'(N * nf));
        for (int i = 0; i < N * nf; i++) begin
            if (base + i < got_q.size()) begin
                e = {img(i % N), (i % N) == 0, (i % W) == W - 1, (i % N) == N - 1};
                check_eq($sformatf("%s_px%0d", tag, i), 32'(got_q[base + i]), 32'(e));
            end
        end
    endtask

    initial begin
        int base, gbase, lat, sofs;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; frame_count = 8'd0;
        repeat (3) @(posedge sensor_clk);
        #1;
        check_eq("rst_ready",   32'(prod_ready), 32'd0);
        check_eq("rst_valid",   32'(out_valid), 32'd0);
        check_eq("rst_markers", 32'({out_sof, out_eol, out_eof}), 32'd0);
        check_eq("rst_busy",    32'(busy), 32'd0);
        check_eq("rst_perr",    32'(proto_err), 32'd0);
        check_eq("rst_fdone",   32'(frames_done), 32'd0);
        check_eq("rst_pixel",   32'(out_pixel), 32'd0);
        @(negedge sensor_clk) rst_n = 1'b1;
        @(posedge sensor_clk); #1;

        // One 4x2 frame, downstream always ready.
        frame_count = 8'd1;
        base = got_q.size();
        pulse_start();
        check_eq("t1_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge sensor_clk); #1;
            lat++;
        end
        check_eq("t1_latency", 32'(lat), 32'd3);
        wait_idle("t1", 200);
        check_pixels("t1", base, 1);
        check_eq("t1_fdone", 32'(frames_done), 32'd1);
        check_eq("t1_perr",  32'(proto_err), 32'd0);

        // Same frame with a randomly stalling consumer.
        rnd_mode = 1'b1;
        base = got_q.size();
        pulse_start();
        wait_idle("t2", 1000);
        rnd_mode = 1'b0;
        check_pixels("t2", base, 1);
        check_eq("t2_fdone", 32'(frames_done), 32'd1);
        check_eq("t2_occ_bound", 32'(max_occ <= DEPTH), 32'd1);

        // Three frames with gaps.
        @(posedge sensor_clk); #1;
        frame_count = 8'd3;
        base  = got_q.size();
        gbase = gap_q.size();
        pulse_start();
        wait_idle("t3", 2000);
        check_pixels("t3", base, 3);
        sofs = 0;
        for (int i = base; i < got_q.size(); i++) sofs += int'(got_q[i].sof);
        check_eq("t3_sofs",  32'(sofs), 32'd3);
        check_eq("t3_fdone", 32'(frames_done), 32'd3);
        check_eq("t3_gaps",  32'(gap_q.size() - gbase), 32'd3);
        for (int k = 1; k < 3; k++) begin
            if (gbase + k < gap_q.size())
                check_eq($sformatf("t3_gap%0d_min", k), 32'(gap_q[gbase + k] >= GAP + 2), 32'd1);
        end

        // Continuous run stopped on the 3rd pixel of frame 2.
        frame_count = 8'd0;
        base = got_q.size();
        pulse_start();
        wait_pixels("t4", base, N + 3);
        pulse_stop();
        wait_idle("t4", 500);
        check_pixels("t4", base, 2);
        check_eq("t4_fdone", 32'(frames_done), 32'd2);

        // Reset in the middle of a frame, then a clean restart.
        frame_count = 8'd1;
        base = got_q.size();
        pulse_start();
        wait_pixels("t5", base, 3);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_ready",   32'(prod_ready), 32'd0);
        check_eq("t5_rst_valid",   32'(out_valid), 32'd0);
        check_eq("t5_rst_markers", 32'({out_sof, out_eol, out_eof}), 32'd0);
        check_eq("t5_rst_busy",    32'(busy), 32'd0);
        check_eq("t5_rst_pixel",   32'(out_pixel), 32'd0);
        repeat (3) @(posedge sensor_clk);
        @(negedge sensor_clk) rst_n = 1'b1;
        @(posedge sensor_clk); #1;
        base = got_q.size();
        pulse_start();
        wait_idle("t5", 300);
        check_pixels("t5", base, 1);
        check_eq("t5_perr", 32'(proto_err), 32'd0);

        // Missing producer valid on one capture: sticky protocol error.
        drop_req = drop_req + 1;
        base = got_q.size();
        pulse_start();
        wait_idle("t6a", 300);
        check_eq("t6_perr_set",   32'(proto_err), 32'd1);
        check_eq("t6_count",      32'(got_q.size() - base), 32'(N));
        pulse_start();
        check_eq("t6_perr_start", 32'(proto_err), 32'd1);
        wait_idle("t6b", 300);
        check_eq("t6_perr_keep",  32'(proto_err), 32'd1);
        check_eq("t6_fdone",      32'(frames_done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
